// File: rtl/cmp_branch_resolver.sv
// Request-side sequencer for a registered 32-bit comparator: one branch condition in flight.
// Optional flag-consistency checking is compiled in with `define CMP_FLAG_CHECK_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; comparator operands hold last values
// WAIT  | counting down comparator latency; flags sampled when count is 0
// RESP  | result presented on rsp_*; held until rsp_ready
module cmp_branch_resolver #(
  parameter int unsigned CMP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cond,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic        cmp_sign,
  output logic [31:0] cmp_op1,
  output logic [31:0] cmp_op2,
  input  logic        cmp_eq,
  input  logic        cmp_neq,
  input  logic        cmp_grt,
  input  logic        cmp_lss,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_taken,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
);

  localparam int unsigned   CW       = $clog2(CMP_LATENCY + 1);
  localparam logic [CW-1:0] LAT_INIT = CW'(CMP_LATENCY);

  localparam logic [2:0] CC_EQ  = 3'b000;
  localparam logic [2:0] CC_NE  = 3'b001;
  localparam logic [2:0] CC_LT  = 3'b100;
  localparam logic [2:0] CC_GE  = 3'b101;
  localparam logic [2:0] CC_LTU = 3'b110;
  localparam logic [2:0] CC_GEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic          sign_q, sign_d;
  logic [2:0]    cond_q, cond_d;
  logic [3:0]    tag_q, tag_d;
  logic          taken_q, taken_d;
  logic          err_q, err_d;

  logic          cond_legal;
  logic          taken_raw;
  logic          flags_ok;

  // Decode uses the condition captured at acceptance, not the live request bus.
  always_comb begin
    cond_legal = 1'b1;
    taken_raw  = 1'b0;
    case (cond_q)
      CC_EQ:          taken_raw = cmp_eq;
      CC_NE:          taken_raw = cmp_neq;
      CC_LT, CC_LTU:  taken_raw = cmp_lss;
      CC_GE, CC_GEU:  taken_raw = cmp_grt | cmp_eq;
      default:        cond_legal = 1'b0;
    endcase
  end

`ifdef CMP_FLAG_CHECK_EN
  assign flags_ok = (({cmp_eq, cmp_grt, cmp_lss} == 3'b100) ||
                     ({cmp_eq, cmp_grt, cmp_lss} == 3'b010) ||
                     ({cmp_eq, cmp_grt, cmp_lss} == 3'b001)) &&
                    (cmp_neq == ~cmp_eq);
`else
  assign flags_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sign_d  = sign_q;
    cond_d  = cond_q;
    tag_d   = tag_q;
    taken_d = taken_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = LAT_INIT;
          op1_d   = req_a;
          op2_d   = req_b;
          sign_d  = (req_cond[2:1] == 2'b10);
          cond_d  = req_cond;
          tag_d   = req_tag;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_RESP;
          taken_d = taken_raw & cond_legal & flags_ok;
          err_d   = ~cond_legal | ~flags_ok;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sign_q  <= 1'b0;
      cond_q  <= '0;
      tag_q   <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sign_q  <= sign_d;
      cond_q  <= cond_d;
      tag_q   <= tag_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign cmp_op1   = op1_q;
  assign cmp_op2   = op2_q;
  assign cmp_sign  = sign_q;
  assign rsp_taken = taken_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;

endmodule
